// File: rtl/timer_dev_pkg.sv
// Register map, CTRL layout and FSM encoding
// shared by the countdown timer.
package timer_dev_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_RSVD   = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer driving one
// CP0 HWInt line; one-shot or auto-reload.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] PRESET_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             wr_ctrl, wr_pre;

  assign wr_ctrl = we && (addr == TMR_CTRL);
  assign wr_pre  = we && (addr == TMR_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= PRESET_RST;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    state_d  = state_q;
    pend_d   = pend_q;

    if (wr_pre) begin
      preset_d = din;
    end
    // FSM set below overrides this clear
    if (wr_ctrl || wr_pre) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = '0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // a CPU CTRL write replaces the whole field
    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(din[3:0]);
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr)
      TMR_CTRL:   dout = {{(WIDTH-4){1'b0}}, ctrl_q};
      TMR_PRESET: dout = preset_q;
      TMR_COUNT:  dout = count_q;
      TMR_RSVD:   dout = '0;
      default:    dout = '0;
    endcase
  end

  assign irq = pend_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed
// scenarios plus randomized bus traffic vs model.
module tb_timer_dev;

  localparam logic [31:0] PRST = 32'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  timer_dev #(
    .WIDTH      (32),
    .PRESET_RST (PRST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Timeline model: a run starts when EN is
  // seen idle; age counts edges since then.
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count = '0;
  bit          m_pend = 0;
  bit          m_run = 0;
  int          m_age = 0;
  longint      m_n = 0;

  function automatic longint fire_age(
    input longint n);
    return ((n < 1) ? 1 : n) + 2;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0]  c;
    logic [31:0] p;
    logic [31:0] cnt;
    bit          pd, run, wc, wp;
    int          age;
    longint      n;
    c = m_ctrl; p = m_preset; cnt = m_count;
    pd = m_pend; run = m_run;
    age = m_age; n = m_n;
    if (reset) begin
      c = '0; p = PRST; cnt = '0;
      pd = 0; run = 0; age = 0; n = 0;
    end else begin
      wc = we && (addr == 2'd0);
      wp = we && (addr == 2'd1);
      if (wp) p = din;
      if (wc || wp) pd = 0;
      if (!m_run) begin
        if (m_ctrl[0]) begin
          run = 1; age = 1;
        end
      end else if (m_age == 1) begin
        n = m_preset; cnt = m_preset; age = 2;
      end else if (m_age < fire_age(m_n)) begin
        if (!m_ctrl[0]) begin
          run = 0;
        end else begin
          age = m_age + 1;
          if (age == fire_age(m_n)) begin
            cnt = '0; pd = 1;
          end else begin
            cnt = 32'(m_n - longint'(age - 2));
          end
        end
      end else begin
        if (m_ctrl[2:1] == 2'b01) begin
          pd = 0; age = 1;
        end else begin
          c[0] = 1'b0; run = 0;
        end
      end
      if (wc) c = din[3:0];
    end
    m_ctrl <= c; m_preset <= p;
    m_count <= cnt; m_pend <= pd;
    m_run <= run; m_age <= age; m_n <= n;
  end

  function automatic logic [31:0] exp_dout(
    input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rexp [4];
    rexp = '{32'd0, PRST, 32'd0, 32'd0};
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      n_chk++;
      if (dout !== rexp[a]) begin
        n_fail++;
        $display("FAIL reset_rd%0d: got %0h want %0h",
                 a, dout, rexp[a]);
      end
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_oneshot();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_chk++;
      if (irq !== (k >= 7)) begin
        n_fail++;
        $display("FAIL oneshot_irq e%0d: got %b want %b",
                 k, irq, (k >= 7));
      end
    end
    addr = 2'd0;
    #1;
    n_chk++;
    if (dout !== 32'h8) begin
      n_fail++;
      $display("FAIL oneshot_en_clr: got %0h want 8",
               dout);
    end
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_hold: got %b want 1", irq);
    end
    wr(2'd0, 32'h8);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_ack: got %b want 0", irq);
    end
  endtask

  task automatic test_reload();
    int pulses = 0;
    int bad = 0;
    logic [31:0] ec;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    for (int k = 1; k <= 20; k++) begin
      tick();
      case (k % 5)
        2:       ec = 32'd3;
        3:       ec = 32'd2;
        4:       ec = 32'd1;
        default: ec = 32'd0;
      endcase
      if (irq === 1'b1) pulses++;
      if (irq !== ((k % 5) == 0) || dout !== ec) begin
        bad++;
        $display("FAIL reload e%0d: irq %b cnt %0d want %b %0d",
                 k, irq, dout, ((k % 5) == 0), ec);
      end
    end
    n_chk++;
    if (bad != 0) n_fail++;
    n_chk++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL reload_pulses: got %0d want 4",
               pulses);
    end
    wr(2'd0, 32'h0);
    tick(); tick();
  endtask

  task automatic test_midcount();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    tick(); tick(); tick();
    n_chk++;
    if (dout !== 32'd3) begin
      n_fail++;
      $display("FAIL mid_pre: got %0d want 3", dout);
    end
    wr(2'd0, 32'h0);
    addr = 2'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_chk++;
      if (dout !== 32'd2 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_frozen: cnt %0d irq %b want 2 0",
                 dout, irq);
      end
    end
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_chk++;
      if (irq !== (k >= 9)) begin
        n_fail++;
        $display("FAIL mid_reen e%0d: got %b want %b",
                 k, irq, (k >= 9));
      end
      if (k == 2) begin
        n_chk++;
        if (dout !== 32'd7) begin
          n_fail++;
          $display("FAIL mid_reload: got %0d want 7",
                   dout);
        end
      end
    end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_im_gate();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_chk++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("FAIL im0_irq e%0d: got %b want 0",
                 k, irq);
      end
    end
    addr = 2'd0;
    #1;
    n_chk++;
    if (dout !== 32'h0) begin
      n_fail++;
      $display("FAIL im0_fired: got %0h want 0", dout);
    end
    wr(2'd0, 32'h8);
    tick();
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL im_set_ack: got %b want 0", irq);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    wr(2'd1, 32'd6);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    tick(); tick(); tick(); tick();
    n_chk++;
    if (dout !== 32'd4) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %0d want 4", dout);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      #1;
      n_chk++;
      if (dout !== 32'd0) begin
        n_fail++;
        $display("FAIL rstmid_rd%0d: got %0h want 0",
                 a, dout);
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (irq !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got %0d pulses want 0",
               bad);
    end
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++;
      if (irq !== (k >= 3)) begin
        n_fail++;
        $display("FAIL preset0 e%0d: got %b want %b",
                 k, irq, (k >= 3));
      end
    end
    wr(2'd0, 32'h0);
  endtask

  task automatic test_random();
    int bad = 0;
    logic [1:0] ra;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(99) == 0);
      we    = ($urandom_range(4) == 0);
      addr  = 2'($urandom_range(3));
      din   = (addr == 2'd1) ?
              32'($urandom_range(8)) : $urandom;
      @(posedge clk);
      #1;
      ra = 2'($urandom_range(3));
      addr = ra;
      #1;
      n_chk++;
      if (dout !== exp_dout(ra) ||
          irq !== (m_pend & m_ctrl[3])) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL rand c%0d a%0d: dout %0h irq %b want %0h %b",
                   i, ra, dout, irq, exp_dout(ra),
                   (m_pend & m_ctrl[3]));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    we = 1'b0;
    addr = 2'd0;
    din = '0;
    test_reset();
    test_oneshot();
    test_reload();
    test_midcount();
    test_im_gate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
